// File: rtl/piso_pkg.sv
// ---------------------------------------------------------------------------
// piso_pkg
//   Shared definitions for the parallel-in / serial-out serializer.
//   - state_t        : serializer FSM states (IDLE, SHIFT)
//   - PISO_WIDTH_DEF : default parallel word width
// ---------------------------------------------------------------------------
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,  // no word shifting
    SHIFT = 1'b1   // shift register is presenting bits
  } state_t;

  localparam int PISO_WIDTH_DEF = 4;

endpackage

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//   Converts parallel words into a bit stream. It has a one-word hold buffer,
//   so an upstream word can be accepted while the previous word is still
//   shifting. Consecutive words leave back to back with no idle cycle.
//
// Parameters
//   WIDTH     : parallel word width, 2..32
//   MSB_FIRST : 1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first
//
// Ports
//   clk          : clock; all state updates on its rising edge
//   reset        : synchronous, active-high reset
//   in_valid     : data_in holds a word to be serialized
//   in_ready     : a word is accepted this cycle (in_valid && in_ready)
//   data_in      : parallel word
//   shift_en     : downstream takes the current serial bit this cycle
//   serial_out   : current serial bit (0 when serial_valid is low)
//   serial_valid : serial_out is meaningful
//   frame_start  : first bit of a word is presented
//   frame_end    : last bit of a word is presented
//   busy         : a word is shifting or a word is held
// ---------------------------------------------------------------------------
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = PISO_WIDTH_DEF,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int unsigned   CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           r_state,      w_state_nxt;
  logic [WIDTH-1:0] r_shift,      w_shift_nxt;
  logic [CW-1:0]    r_cnt,        w_cnt_nxt;
  logic [WIDTH-1:0] r_hold,       w_hold_nxt;
  logic             r_hold_valid, w_hold_valid_nxt;

  logic w_xfer;
  logic w_last;
  logic w_valid;
  logic w_wrap;

  // Move the register one position toward the serial output.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  assign in_ready = !reset && !r_hold_valid;
  assign w_xfer   = in_valid && in_ready;
  assign w_last   = (r_cnt == CNT_LAST);
  assign w_valid  = (r_state == SHIFT);
  // The last bit of the current word is consumed on this edge.
  assign w_wrap   = w_valid && shift_en && w_last;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_cnt_nxt        = r_cnt;
    w_hold_nxt       = r_hold;
    w_hold_valid_nxt = r_hold_valid;

    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          w_shift_nxt = data_in;
          w_cnt_nxt   = '0;
          w_state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        if (shift_en && !w_last) begin
          w_shift_nxt = shift_once(r_shift);
          w_cnt_nxt   = r_cnt + CW'(1);
        end else if (w_wrap) begin
          // Reload without a gap: the held word is older, so it goes first.
          w_cnt_nxt = '0;
          if (r_hold_valid) begin
            w_shift_nxt      = r_hold;
            w_hold_valid_nxt = 1'b0;
          end else if (w_xfer) begin
            w_shift_nxt = data_in;
          end else begin
            w_shift_nxt = '0;
            w_state_nxt = IDLE;
          end
        end

        // A word accepted mid-frame parks in the hold buffer. A transfer can
        // only happen when the hold buffer is empty, so nothing is overwritten.
        if (w_xfer && !w_wrap) begin
          w_hold_nxt       = data_in;
          w_hold_valid_nxt = 1'b1;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values. The data registers are cleared on reset
  // too: the shift register drives serial_out, and a stale hold word must
  // never come back after an aborted frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_cnt        <= w_cnt_nxt;
      r_hold       <= w_hold_nxt;
      r_hold_valid <= w_hold_valid_nxt;
    end
  end

  assign serial_valid = w_valid;
  assign serial_out   = w_valid && (MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0]);
  assign frame_start  = w_valid && (r_cnt == '0);
  assign frame_end    = w_valid && w_last;
  assign busy         = w_valid || r_hold_valid;

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
//   Two serializers (MSB-first and LSB-first, WIDTH=4) share one set of
//   inputs. Directed scenarios compare the outputs against hand-derived
//   tables. A randomized run compares them against a word-queue reference
//   model: accepted words queue up (at most two outstanding), and the front
//   word is emitted one bit per shift_en cycle.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

  localparam int WIDTH = piso_pkg::PISO_WIDTH_DEF;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             shift_en;
  logic [WIDTH-1:0] data_in;

  logic m_in_ready, m_serial_out, m_serial_valid, m_frame_start, m_frame_end, m_busy;
  logic l_in_ready, l_serial_out, l_serial_valid, l_frame_start, l_frame_end, l_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(m_in_ready),
    .data_in(data_in), .shift_en(shift_en), .serial_out(m_serial_out),
    .serial_valid(m_serial_valid), .frame_start(m_frame_start),
    .frame_end(m_frame_end), .busy(m_busy)
  );

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(l_in_ready),
    .data_in(data_in), .shift_en(shift_en), .serial_out(l_serial_out),
    .serial_valid(l_serial_valid), .frame_start(l_frame_start),
    .frame_end(l_frame_end), .busy(l_busy)
  );

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] m_words[$];  // accepted words not yet fully sent
  int               m_pos = 0;   // next bit position (in send order) of front word

  task automatic model_step();
    logic acc;
    acc = in_valid && !reset && (m_words.size() < 2);
    if (reset) begin
      m_words.delete();
      m_pos = 0;
    end else begin
      if (m_words.size() > 0 && shift_en) begin
        if (m_pos == WIDTH - 1) begin
          void'(m_words.pop_front());
          m_pos = 0;
        end else begin
          m_pos++;
        end
      end
      if (acc) m_words.push_back(data_in);
    end
  endtask

  always @(posedge clk) model_step();

  // Expected {out, valid, frame_start, frame_end, busy, in_ready}.
  function automatic logic [5:0] model_exp(input bit msb);
    logic [WIDTH-1:0] w;
    logic             v;
    logic             o;
    v = (m_words.size() > 0);
    w = v ? m_words[0] : '0;
    o = v && (msb ? w[WIDTH-1-m_pos] : w[m_pos]);
    return {o, v, v && (m_pos == 0), v && (m_pos == WIDTH - 1), v,
            !reset && (m_words.size() < 2)};
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one accepted word in the current (idle) cycle.
  task automatic send_word(input logic [WIDTH-1:0] w);
    in_valid = 1'b1;
    data_in  = w;
    shift_en = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [5:0] got;
    reset = 1'b1; in_valid = 1'b1; data_in = 4'hF; shift_en = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    n_checks++;
    if ({m_in_ready, l_in_ready} !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_in_ready: got %b expected 00", {m_in_ready, l_in_ready});
    end
    tick();
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    got = {m_serial_out, m_serial_valid, m_frame_start, m_frame_end, m_busy, m_in_ready};
    n_checks++;
    if (got !== 6'b000001) begin
      n_errors++;
      $display("FAIL reset_msb {out,valid,fs,fe,busy,rdy}: got %b expected 000001", got);
    end
    got = {l_serial_out, l_serial_valid, l_frame_start, l_frame_end, l_busy, l_in_ready};
    n_checks++;
    if (got !== 6'b000001) begin
      n_errors++;
      $display("FAIL reset_lsb {out,valid,fs,fe,busy,rdy}: got %b expected 000001", got);
    end
    tick();
  endtask

  task automatic test_basic();
    logic [0:4] t_o  = 5'b10110;
    logic [0:4] t_v  = 5'b11110;
    logic [0:4] t_fs = 5'b10000;
    logic [0:4] t_fe = 5'b00010;
    logic [5:0] got, exp;
    send_word(4'b1011);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp = {t_o[i], t_v[i], t_fs[i], t_fe[i], t_v[i], 1'b1};
      got = {m_serial_out, m_serial_valid, m_frame_start, m_frame_end, m_busy, m_in_ready};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL basic cycle %0d {out,valid,fs,fe,busy,rdy}: got %b expected %b", i, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [0:8] t_o  = 9'b000100100;
    logic [0:8] t_v  = 9'b111111110;
    logic [0:8] t_fs = 9'b100010000;
    logic [0:8] t_fe = 9'b000100010;
    logic [0:8] t_r  = 9'b100011111;
    logic [5:0] got, exp;
    send_word(4'b0001);
    for (int i = 0; i < 9; i++) begin
      in_valid = (i == 0);
      data_in  = 4'b0010;
      @(negedge clk);
      exp = {t_o[i], t_v[i], t_fs[i], t_fe[i], t_v[i], t_r[i]};
      got = {m_serial_out, m_serial_valid, m_frame_start, m_frame_end, m_busy, m_in_ready};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL back_to_back cycle %0d {out,valid,fs,fe,busy,rdy}: got %b expected %b", i, got, exp);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stall();
    logic [0:7] t_se = 8'b11000111;
    logic [0:7] t_o  = 8'b11000000;
    logic [0:7] t_v  = 8'b11111110;
    logic [0:7] t_fs = 8'b10000000;
    logic [0:7] t_fe = 8'b00000010;
    logic [5:0] got, exp;
    send_word(4'b1100);
    for (int i = 0; i < 8; i++) begin
      shift_en = t_se[i];
      @(negedge clk);
      exp = {t_o[i], t_v[i], t_fs[i], t_fe[i], t_v[i], 1'b1};
      got = {m_serial_out, m_serial_valid, m_frame_start, m_frame_end, m_busy, m_in_ready};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL stall cycle %0d {out,valid,fs,fe,busy,rdy}: got %b expected %b", i, got, exp);
      end
      tick();
    end
    shift_en = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    logic [0:5] t_rst = 6'b001000;
    logic [0:5] t_o   = 6'b101000;
    logic [0:5] t_v   = 6'b111000;
    logic [0:5] t_fs  = 6'b100000;
    logic [0:5] t_r   = 6'b110111;
    logic [5:0] got, exp;
    send_word(4'b1010);
    for (int i = 0; i < 6; i++) begin
      reset = t_rst[i];
      @(negedge clk);
      exp = {t_o[i], t_v[i], t_fs[i], 1'b0, t_v[i], t_r[i]};
      got = {m_serial_out, m_serial_valid, m_frame_start, m_frame_end, m_busy, m_in_ready};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL reset_mid cycle %0d {out,valid,fs,fe,busy,rdy}: got %b expected %b", i, got, exp);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  task automatic test_lsb_first();
    logic [0:4] t_o  = 5'b10000;
    logic [0:4] t_v  = 5'b11110;
    logic [0:4] t_fs = 5'b10000;
    logic [0:4] t_fe = 5'b00010;
    logic [5:0] got, exp;
    send_word(4'b0001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp = {t_o[i], t_v[i], t_fs[i], t_fe[i], t_v[i], 1'b1};
      got = {l_serial_out, l_serial_valid, l_frame_start, l_frame_end, l_busy, l_in_ready};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL lsb_first cycle %0d {out,valid,fs,fe,busy,rdy}: got %b expected %b", i, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_third_word();
    logic [0:12] t_o  = 13'b1001011011100;
    logic [0:12] t_v  = 13'b1111111111110;
    logic [0:12] t_fs = 13'b1000100010000;
    logic [0:12] t_fe = 13'b0001000100010;
    logic [0:12] t_r  = 13'b1000100011111;
    logic [5:0]  got, exp;
    send_word(4'b1001);
    for (int i = 0; i < 13; i++) begin
      in_valid = (i <= 4);
      data_in  = (i == 0) ? 4'b0110 : 4'b1110;
      @(negedge clk);
      exp = {t_o[i], t_v[i], t_fs[i], t_fe[i], t_v[i], t_r[i]};
      got = {m_serial_out, m_serial_valid, m_frame_start, m_frame_end, m_busy, m_in_ready};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL third_word cycle %0d {out,valid,fs,fe,busy,rdy}: got %b expected %b", i, got, exp);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [5:0] got, exp;
    reset = 1'b1; in_valid = 1'b0;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(99) < 2);
      in_valid = 1'($urandom_range(1));
      data_in  = WIDTH'($urandom);
      shift_en = ($urandom_range(3) != 0);
      @(negedge clk);
      exp = model_exp(1'b1);
      got = {m_serial_out, m_serial_valid, m_frame_start, m_frame_end, m_busy, m_in_ready};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL random_msb cycle %0d {out,valid,fs,fe,busy,rdy}: got %b expected %b", c, got, exp);
      end
      exp = model_exp(1'b0);
      got = {l_serial_out, l_serial_valid, l_frame_start, l_frame_end, l_busy, l_in_ready};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL random_lsb cycle %0d {out,valid,fs,fe,busy,rdy}: got %b expected %b", c, got, exp);
      end
      tick();
    end
    reset = 1'b0; in_valid = 1'b0; shift_en = 1'b1;
  endtask

  // ---------------- sequence ----------------
  initial begin
    reset = 1'b1; in_valid = 1'b0; shift_en = 1'b0; data_in = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_reset_mid_frame();
    test_lsb_first();
    test_third_word();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-005 Port in_valid SHALL be an input, 1 bit: data_in holds a word to be serialized.
REQ-006 Port in_ready SHALL be an output, 1 bit: the block accepts data_in this cycle.
REQ-007 Port data_in SHALL be an input, WIDTH bits: the parallel word from the upstream PIPO register's parallel_out.
REQ-008 Port shift_en SHALL be an input, 1 bit: the downstream consumer takes the current serial bit this cycle.
REQ-009 Port serial_out SHALL be an output, 1 bit: the current serial bit.
REQ-010 Port serial_valid SHALL be an output, 1 bit: serial_out is meaningful.
REQ-011 Port frame_start SHALL be an output, 1 bit: high while the first bit of a word is presented.
REQ-012 Port frame_end SHALL be an output, 1 bit: high while the last bit of a word is presented.
REQ-013 Port busy SHALL be an output, 1 bit: high while a word is shifting or a word is held.

Function
REQ-014 A transfer SHALL occur on a rising edge when in_valid && in_ready are both high; in_ready SHALL equal !reset && !hold_valid.
REQ-015 The block SHALL use a two-state FSM: IDLE (no word shifting) and SHIFT (shift register active). It SHALL also contain a one-word hold buffer (hold_reg, hold_valid) and a bit counter cnt in the range 0..WIDTH-1.
REQ-016 In IDLE, a transfer SHALL load data_in directly into the shift register, set cnt=0 and enter SHIFT; the first bit SHALL appear on the next cycle, giving a latency of one cycle.
REQ-017 In SHIFT, serial_valid SHALL be 1, and serial_out SHALL be the shift-register MSB when MSB_FIRST=1 or its LSB when MSB_FIRST=0.
REQ-018 In SHIFT, when shift_en=0, the shift register, cnt and all outputs SHALL hold their values (stall).
REQ-019 In SHIFT, when shift_en=1 and cnt<WIDTH-1, the register SHALL shift one position toward the output and cnt SHALL increment.
REQ-020 In SHIFT, when shift_en=1 and cnt==WIDTH-1, the next word SHALL load with cnt=0 and the FSM SHALL stay in SHIFT, so there is no idle gap. The next word SHALL come from hold_reg if hold_valid=1, in which case hold_valid clears in the same cycle. Otherwise it SHALL come from data_in if a transfer occurs in that same cycle. If neither applies, the FSM SHALL return to IDLE.
REQ-021 In SHIFT, a transfer that is not consumed under REQ-020 SHALL be written into hold_reg and set hold_valid=1.
REQ-022 serial_out SHALL be 0 whenever serial_valid=0.
REQ-023 frame_start SHALL equal serial_valid && cnt==0, and frame_end SHALL equal serial_valid && cnt==WIDTH-1.
REQ-024 busy SHALL equal (state==SHIFT) || hold_valid.
REQ-025 When hold_valid=1, in_ready SHALL be 0, and data_in SHALL be ignored until the hold buffer drains.

Reset
REQ-026 While reset=1 at a clock edge, the next state SHALL be: state=IDLE, cnt=0, shift register=0, hold_reg=0, hold_valid=0.
REQ-027 After reset the outputs SHALL be: serial_out=0, serial_valid=0, frame_start=0, frame_end=0, busy=0; in_ready SHALL be 0 during reset and 1 on the first cycle after reset.
REQ-028 A reset asserted mid-frame SHALL abort the frame and discard any held word; no partial bits SHALL appear after reset deasserts.

Structure
REQ-029 A shared package piso_pkg SHALL define the state_t enum (IDLE, SHIFT) and the default width constant PISO_WIDTH_DEF=4.
REQ-030 The block SHALL be a single module with no sub-modules; cnt SHALL be $clog2(WIDTH) bits wide.

Verification (WIDTH=4 unless stated)
REQ-031 Reset, then transfer 4'b1011 with shift_en=1 -> serial_out 1,0,1,1 on four consecutive cycles starting one cycle after the transfer; frame_start on bit 1 and frame_end on bit 4; serial_valid=0 afterwards.
REQ-032 Transfer 4'b0001, then 4'b0010 offered during shifting -> eight contiguous valid bits 0,0,0,1,0,0,1,0 with no gap; in_ready=0 while the hold buffer is full.
REQ-033 Transfer 4'b1100 and drop shift_en for 3 cycles after bit 2 -> serial_out stays at 0 (bit index 1) through the stall, cnt is unchanged, and the full sequence is 1,1,0,0.
REQ-034 Transfer 4'b1010 and assert reset after 2 bits -> the next cycle shows serial_valid=0, busy=0, in_ready=1, with no remaining bits emitted.
REQ-035 With MSB_FIRST=0, transfer 4'b0001 -> serial_out 1,0,0,0.
REQ-036 Offer a third word while shifting with the hold buffer full -> in_ready=0 and the word is not accepted; it is accepted in the cycle after the hold buffer moves to the shift register, and output order is preserved.
